load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port req, input, 1 bit: core access request, sampled only in IDLE.
REQ-004 SHALL have port funct3, input, 3 bits: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (loads); 000 SB, 001 SH, 010 SW (stores).
REQ-005 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port addr, input, 32 bits: byte address.
REQ-007 SHALL have port wdata, input, 32 bits: store data; the low byte or halfword is used for SB/SH.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port fault, output, 1 bit: valid with done; marks a misaligned or illegal access.
REQ-011 SHALL have port rdata, output, 32 bits: extended load result, held until the next done.
REQ-012 SHALL have ports mem_read and mem_write, output, 1 bit each: data-memory strobes.
REQ-013 SHALL have port mem_addr, output, 6 bits: word index equal to the latched addr[7:2].
REQ-014 SHALL have port mem_wdata, output, 32 bits: word to write.
REQ-015 SHALL have port mem_rdata, input, 32 bits: combinational read data from the data memory.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WRITE, RMW_RD, RMW_WR, DONE, ERR.
REQ-017 SHALL, in IDLE with req=1, latch addr, funct3, we and wdata, then transition as follows:
- illegal or misaligned access -> ERR
- load -> LOAD
- SW -> WRITE
- SB/SH -> RMW_RD
REQ-018 SHALL treat an access as misaligned when LH/LHU/SH has addr[0]=1, or LW/SW has addr[1:0]!=0.
REQ-019 SHALL treat funct3 011, 110 and 111 as illegal, and also funct3 100 and 101 when we=1.
REQ-020 SHALL, in LOAD, assert mem_read and register the extracted lane into rdata, then go to DONE:
- LB/LH: sign-extended
- LBU/LHU: zero-extended
- LW: full word
REQ-021 SHALL, in WRITE, assert mem_write with mem_wdata=wdata, then go to DONE.
REQ-022 SHALL, in RMW_RD, assert mem_read and capture mem_rdata; in RMW_WR, assert mem_write with the captured word with the addressed byte (addr[1:0]) or halfword (addr[1]) replaced; then go to DONE.
REQ-023 SHALL, in DONE, pulse done=1 with fault=0, then go to IDLE.
REQ-024 SHALL, in ERR, pulse done=1 with fault=1, issue no memory strobe, leave rdata unchanged, then go to IDLE.
REQ-025 SHALL produce done at these cycles after the accepting edge: load 2, SW 2, SB/SH 3, fault 1.
REQ-026 SHALL ignore req whenever busy=1; requests are neither queued nor merged.
REQ-027 SHALL accept a new req in the IDLE cycle that follows DONE or ERR.
REQ-028 SHALL ignore addr[31:8], so addresses wrap modulo 256 bytes.
REQ-029 SHALL never assert mem_read and mem_write in the same cycle.
REQ-030 SHALL decode mem_read and mem_write from the state register only.

Reset
REQ-031 SHALL, on a rising edge with rst_n=0, force:
- state to IDLE
- rdata to 0
- the latched request and captured word to 0
REQ-032 SHALL hold done=0, fault=0, busy=0, mem_read=0 and mem_write=0 in the cycle after reset.
REQ-033 SHALL let a write strobe already asserted at the edge where rst_n is sampled low take effect, and SHALL issue no further strobe until a new req is accepted; an aborted access produces no done.

Configuration
REQ-034 SHALL, with macro LSU_FAULT_EN defined, apply REQ-018, REQ-019 and REQ-024.
REQ-035 SHALL, with LSU_FAULT_EN undefined:
- tie fault to 0 and remove the ERR state
- force misaligned addresses to alignment (LH/LHU/SH clear addr[0]; LW/SW clear addr[1:0])
- treat illegal funct3 as LW when we=0 and SW when we=1
- perform the access normally

Verification
REQ-036 SHALL cover: memory word 1 = 9; LW addr 0x4 -> done 2 cycles after accept, rdata=0x00000009, fault=0.
REQ-037 SHALL cover: memory word 2 = 0x00000019; SB addr 0x9 wdata 0x000000AB -> done at 3 cycles, word 2 = 0x0000AB19; LB addr 0x9 -> rdata=0xFFFFFFAB; LBU addr 0x9 -> rdata=0x000000AB.
REQ-038 SHALL cover: SH addr 0x2 wdata 0x00008001 onto word 0 = 0x00000011 -> word 0 = 0x80010011; LH addr 0x2 -> rdata=0xFFFF8001; LHU addr 0x2 -> rdata=0x00008001.
REQ-039 SHALL cover: with LSU_FAULT_EN, LW addr 0x5 -> done 1 cycle after accept, fault=1, no strobe, rdata unchanged; without it, the same request reads word 1 -> rdata=0x00000009.
REQ-040 SHALL cover: req held high for 10 cycles with LW addr 0x0 -> accepts at the IDLE edges only (every third edge), each done with rdata=0x00000011; with addr 0x104 -> reads word 1.
REQ-041 SHALL cover: rst_n low during RMW_RD of an SB -> memory unchanged, no done, busy=0 after the reset edge, and the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store engine in front of a
// 64-word data memory. Sub-word stores are done as read-modify-write.
// Optional feature macro: LSU_FAULT_EN. When it is defined, misaligned or
// illegal requests finish through the ERR state with fault=1. When it is
// undefined, such requests are coerced into legal, aligned accesses instead.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RMW_RD,
        RMW_WR,
`ifdef LSU_FAULT_EN
        DONE,
        ERR
`else
        DONE
`endif
    } state_t;

    state_t      state, state_nxt;

    logic [7:0]  addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        req_illegal;
    logic [2:0]  eff_funct3;
    logic [7:0]  eff_addr;
`ifdef LSU_FAULT_EN
    logic        req_misaligned;
`endif

    logic [31:0] lane;
    logic [31:0] load_val;
    logic [3:0]  lane_mask;
    logic [31:0] wdata_rep;
    logic [31:0] merged_word;

    // Address bits above the 256-byte window play no part in the access.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:8];

    // Classify the incoming request and derive the funct3/address to latch.
    always_comb begin
        req_illegal = (funct3[1:0] == 2'b11) || (funct3[2] && (funct3[1] || we));
`ifdef LSU_FAULT_EN
        eff_funct3     = funct3;
        eff_addr       = addr[7:0];
        req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        // Illegal codes fall back to a full-word access, then the address is
        // forced onto the natural boundary of the resulting access size.
        eff_funct3 = req_illegal ? 3'b010 : funct3;
        eff_addr   = addr[7:0];
        case (eff_funct3[1:0])
            2'b01:   eff_addr[0]   = 1'b0;
            2'b10:   eff_addr[1:0] = 2'b00;
            default: ;
        endcase
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
`ifdef LSU_FAULT_EN
                    if (req_illegal || req_misaligned) state_nxt = ERR;
                    else
`endif
                    if (!we)                             state_nxt = LOAD;
                    else if (eff_funct3[1:0] == 2'b10)   state_nxt = WRITE;
                    else                                 state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = DONE;
            WRITE:   state_nxt = DONE;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
`ifdef LSU_FAULT_EN
            ERR:     state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the request when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
        end else if (state == IDLE && req) begin
            addr_q   <= eff_addr;
            funct3_q <= eff_funct3;
            wdata_q  <= wdata;
        end
    end

    // Extract and extend the addressed lane of the memory word.
    always_comb begin
        lane = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // Build the write word: captured word with the addressed lanes replaced.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
        merged_word = {lane_mask[3] ? wdata_rep[31:24] : word_q[31:24],
                       lane_mask[2] ? wdata_rep[23:16] : word_q[23:16],
                       lane_mask[1] ? wdata_rep[15:8]  : word_q[15:8],
                       lane_mask[0] ? wdata_rep[7:0]   : word_q[7:0]};
    end

    // Load result and read-modify-write capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata  <= '0;
            word_q <= '0;
        end else begin
            if (state == LOAD)   rdata  <= load_val;
            if (state == RMW_RD) word_q <= mem_rdata;
        end
    end

    assign busy      = (state != IDLE);
    assign mem_read  = (state == LOAD)  || (state == RMW_RD);
    assign mem_write = (state == WRITE) || (state == RMW_WR);
    assign mem_addr  = addr_q[7:2];
    assign mem_wdata = (state == RMW_WR) ? merged_word : wdata_q;
`ifdef LSU_FAULT_EN
    assign done  = (state == DONE) || (state == ERR);
    assign fault = (state == ERR);
`else
    assign done  = (state == DONE);
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for
// multi-cycle corners and randomized traffic against a byte-level model.
// Honours LSU_FAULT_EN the same way as the design.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic        mem_read, mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .funct3(funct3), .we(we),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory with a preload port for the bench.
    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (pl_en)          mem[pl_idx]   <= pl_val;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    int both_strobes = 0;
    always @(negedge clk) if (mem_read && mem_write) both_strobes++;

    int checks = 0;
    int errors = 0;

    // Reference model state: memory as 256 bytes, plus the expected rdata.
    logic [7:0]  ref_b [0:255];
    logic [31:0] ref_rdata;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] e_rdata;
        logic        e_fault;
        int          e_lat;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int unsigned w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    task automatic preload(input int unsigned w, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 6'(w); pl_val = v;
        @(posedge clk); #1 pl_en = 1'b0;
        for (int unsigned i = 0; i < 4; i++) ref_b[4*w+i] = 8'((v >> (8*i)) & 32'hFF);
    endtask

    // Apply the architectural rules to one request; updates ref_b / ref_rdata.
    task automatic model(input logic w, input logic [2:0] f3i, input logic [31:0] a32,
                         input logic [31:0] wd, output logic e_fault, output int e_lat,
                         output int e_str);
        int unsigned a, size;
        logic [2:0]  f3;
        logic        ill, mis;
        logic [31:0] v;
        f3   = f3i;
        a    = a32 % 256;
        ill  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (w && (f3 == 4 || f3 == 5));
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        mis  = !ill && (a % size != 0);
        e_fault = 1'b0;
`ifdef LSU_FAULT_EN
        if (ill || mis) begin
            e_fault = 1'b1; e_lat = 1; e_str = 0;
            return;
        end
`else
        if (ill) begin f3 = 3'd2; size = 4; end
        a = a - a % size;
`endif
        if (!w) begin
            v = '0;
            for (int unsigned i = 0; i < size; i++) v = v | (32'(ref_b[a+i]) << (8*i));
            if (f3 < 4 && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            ref_rdata = v;
            e_lat = 2; e_str = 1;
        end else begin
            for (int unsigned i = 0; i < size; i++) ref_b[a+i] = 8'((wd >> (8*i)) & 32'hFF);
            e_lat = (size == 4) ? 2 : 3;
            e_str = (size == 4) ? 1 : 2;
        end
    endtask

    // Issue one request from IDLE and check it against the model.
    task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string tag,
                         output int o_lat, output logic o_fault, output logic [31:0] o_rdata);
        logic e_fault, got;
        int   e_lat, e_str, str;
        model(w, f3, a, wd, e_fault, e_lat, e_str);
        @(negedge clk);
        chk({tag, " busy_before_req"}, 32'(busy), 32'd0);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1 req = 1'b0;
        got = 1'b0; str = 0; o_lat = 0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (mem_read)  str++;
            if (mem_write) str++;
            if (done) begin got = 1'b1; o_lat = n; end
        end
        o_fault = fault; o_rdata = rdata;
        if (!got) begin
            chk({tag, " done_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " latency"}, 32'(o_lat), 32'(e_lat));
            chk({tag, " fault"},   32'(fault), 32'(e_fault));
            chk({tag, " rdata"},   rdata, ref_rdata);
            chk({tag, " strobes"}, 32'(str), 32'(e_str));
        end
    endtask

    initial begin
        int          lat;
        logic        flt;
        logic [31:0] rd;
        logic        got;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        ref_rdata = '0;

        // Preload memory while held in reset.
        for (int unsigned w = 0; w < 64; w++) preload(w, $urandom);
        preload(0, 32'h0000_0011);
        preload(1, 32'h0000_0009);
        preload(2, 32'h0000_0019);

        @(negedge clk);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset done",      32'(done),      32'd0);
        chk("reset fault",     32'(fault),     32'd0);
        chk("reset mem_read",  32'(mem_read),  32'd0);
        chk("reset mem_write", 32'(mem_write), 32'd0);
        chk("reset rdata",     rdata,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset busy", 32'(busy), 32'd0);
        chk("post-reset done", 32'(done), 32'd0);

        // req held high: accepted only at IDLE edges, every third edge.
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("hold busy k=%0d", k), 32'(busy), 32'((k % 3) != 2));
            chk($sformatf("hold done k=%0d", k), 32'(done), 32'((k % 3) == 1));
            if (done) chk($sformatf("hold rdata k=%0d", k), rdata, 32'h0000_0011);
        end
        req = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 5 && !got; n++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("hold last done", 32'(got), 32'd1);
        chk("hold last rdata", rdata, 32'h0000_0011);
        ref_rdata = 32'h0000_0011;

        // Directed vectors; stores list the rdata they must leave untouched.
        tbl[0] = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,         32'h0000_0009, 1'b0, 2};
        tbl[1] = '{1'b1, 3'b000, 32'h0000_0009, 32'h0000_00AB, 32'h0000_0009, 1'b0, 3};
        tbl[2] = '{1'b0, 3'b000, 32'h0000_0009, 32'h0,         32'hFFFF_FFAB, 1'b0, 2};
        tbl[3] = '{1'b0, 3'b100, 32'h0000_0009, 32'h0,         32'h0000_00AB, 1'b0, 2};
        tbl[4] = '{1'b1, 3'b001, 32'h0000_0002, 32'h0000_8001, 32'h0000_00AB, 1'b0, 3};
        tbl[5] = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,         32'hFFFF_8001, 1'b0, 2};
        tbl[6] = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'h0000_8001, 1'b0, 2};
`ifdef LSU_FAULT_EN
        tbl[7] = '{1'b0, 3'b010, 32'h0000_0005, 32'h0,         32'h0000_8001, 1'b1, 1};
`else
        tbl[7] = '{1'b0, 3'b010, 32'h0000_0005, 32'h0,         32'h0000_0009, 1'b0, 2};
`endif
        tbl[8] = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'h0000_0009, 1'b0, 2};
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, $sformatf("vec%0d", i), lat, flt, rd);
            chk($sformatf("vec%0d tbl_latency", i), 32'(lat), 32'(tbl[i].e_lat));
            chk($sformatf("vec%0d tbl_fault", i),   32'(flt), 32'(tbl[i].e_fault));
            chk($sformatf("vec%0d tbl_rdata", i),   rd,       tbl[i].e_rdata);
        end
        chk("word2 after SB", mem[2], 32'h0000_AB19);
        chk("word0 after SH", mem[0], 32'h8001_0011);

        // Reset in the read phase of an SB: aborted, no write, no done.
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h1; wdata = 32'h55;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("abort in RMW_RD", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort busy",      32'(busy),      32'd0);
        chk("abort done",      32'(done),      32'd0);
        chk("abort rdata",     rdata,          32'd0);
        rst_n = 1'b1;
        ref_rdata = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("abort quiet done n=%0d", n),  32'(done),      32'd0);
            chk($sformatf("abort quiet write n=%0d", n), 32'(mem_write), 32'd0);
        end
        chk("abort word0 unchanged", mem[0], 32'h8001_0011);
        do_op(1'b0, 3'b010, 32'h0, 32'h0, "after abort LW", lat, flt, rd);
        chk("after abort rdata", rd, 32'h8001_0011);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $sformatf("rnd%0d", i), lat, flt, rd);
        end

        for (int unsigned w = 0; w < 64; w++) chk($sformatf("final word%0d", w), mem[w], ref_word(w));
        chk("read/write strobe overlap", 32'(both_strobes), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
